// File: rtl/datamem_port_arbiter_pkg.sv
// Shared constants for the data-memory port-B arbiter: memory geometry,
// arbiter state encodings and the priority-owner flag.
package datamem_port_arbiter_pkg;

  localparam int DATAMEM_BITS  = 12;
  localparam int DATAMEM_WIDTH = 32;
  localparam int VEC_LANES     = 4;

  localparam logic [3:0] WE_NONE = 4'h0;
  localparam logic [3:0] WE_FULL = 4'hF;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_V_BEAT  = 2'd1,
    ARB_V_DRAIN = 2'd2,
    ARB_CON     = 2'd3
  } arb_state_e;

  typedef enum logic {
    OWNER_VEC = 1'b0,
    OWNER_CON = 1'b1
  } arb_owner_e;

endpackage

// File: rtl/datamem_port_arbiter.sv
// Shares data-memory port B between the protocol controller (single words) and
// the vector coprocessor (4-word bursts), alternating priority on ties.
module datamem_port_arbiter
  import datamem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = DATAMEM_BITS,
  parameter int DATA_W = DATAMEM_WIDTH,
  parameter int LANES  = VEC_LANES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              v_req,
  input  logic              v_we,
  input  logic [ADDR_W-1:0] v_addr,
  input  logic [DATA_W-1:0] v_wdata0,
  input  logic [DATA_W-1:0] v_wdata1,
  input  logic [DATA_W-1:0] v_wdata2,
  input  logic [DATA_W-1:0] v_wdata3,
  output logic              v_gnt,
  output logic              v_done,
  output logic [DATA_W-1:0] v_rdata0,
  output logic [DATA_W-1:0] v_rdata1,
  output logic [DATA_W-1:0] v_rdata2,
  output logic [DATA_W-1:0] v_rdata3,
  input  logic              con_req,
  input  logic [3:0]        con_we,
  input  logic [ADDR_W-1:0] con_addr,
  input  logic [DATA_W-1:0] con_wdata,
  output logic              con_gnt,
  output logic              con_rvalid,
  output logic [DATA_W-1:0] con_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  arb_state_e        state_q;
  arb_owner_e        last_q;
  logic [1:0]        beat_q;
  logic              store_q;
  logic              con_rd_q;
  logic [ADDR_W-1:0] base_q;
  logic [DATA_W-1:0] lane_q   [LANES];
  logic [DATA_W-1:0] gather_q [LANES];
  logic [DATA_W-1:0] v_rdata_q[LANES];

  logic [ADDR_W-1:0] mem_addr_q;
  logic [3:0]        mem_we_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic              v_gnt_q;
  logic              v_done_q;
  logic              con_gnt_q;
  logic              con_rvalid_q;

  logic       vec_win;
  logic       con_win;
  logic [1:0] beat_nxt;
  logic [1:0] beat_prv;
  logic       last_beat;

  // On a tie the master that did not win last time goes first.
  assign vec_win   = v_req & (~con_req | (last_q == OWNER_CON));
  assign con_win   = con_req & ~vec_win;
  assign beat_nxt  = beat_q + 2'd1;
  assign beat_prv  = beat_q - 2'd1;
  assign last_beat = (beat_q == 2'(LANES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ARB_IDLE;
      last_q       <= OWNER_CON;
      beat_q       <= '0;
      store_q      <= 1'b0;
      con_rd_q     <= 1'b0;
      base_q       <= '0;
      mem_addr_q   <= '0;
      mem_we_q     <= WE_NONE;
      mem_wdata_q  <= '0;
      v_gnt_q      <= 1'b0;
      v_done_q     <= 1'b0;
      con_gnt_q    <= 1'b0;
      con_rvalid_q <= 1'b0;
      for (int i = 0; i < LANES; i++) begin
        lane_q[i]    <= '0;
        gather_q[i]  <= '0;
        v_rdata_q[i] <= '0;
      end
    end else begin
      v_gnt_q      <= 1'b0;
      v_done_q     <= 1'b0;
      con_gnt_q    <= 1'b0;
      con_rvalid_q <= 1'b0;
      unique case (state_q)
        ARB_IDLE: begin
          mem_we_q <= WE_NONE;
          if (vec_win) begin
            state_q     <= ARB_V_BEAT;
            last_q      <= OWNER_VEC;
            beat_q      <= '0;
            store_q     <= v_we;
            base_q      <= v_addr;
            lane_q[0]   <= v_wdata0;
            lane_q[1]   <= v_wdata1;
            lane_q[2]   <= v_wdata2;
            lane_q[3]   <= v_wdata3;
            mem_addr_q  <= v_addr;
            mem_we_q    <= v_we ? WE_FULL : WE_NONE;
            mem_wdata_q <= v_wdata0;
            v_gnt_q     <= 1'b1;
          end else if (con_win) begin
            state_q     <= ARB_CON;
            last_q      <= OWNER_CON;
            con_rd_q    <= (con_we == WE_NONE);
            mem_addr_q  <= con_addr;
            mem_we_q    <= con_we;
            mem_wdata_q <= con_wdata;
            con_gnt_q   <= 1'b1;
          end
        end
        ARB_V_BEAT: begin
          // Read data lags the address by one cycle, so beat k returns lane k-1.
          if (!store_q && beat_q != 2'd0) begin
            gather_q[beat_prv] <= mem_rdata;
          end
          if (last_beat) begin
            mem_we_q <= WE_NONE;
            if (store_q) begin
              state_q  <= ARB_IDLE;
              v_done_q <= 1'b1;
            end else begin
              state_q <= ARB_V_DRAIN;
            end
          end else begin
            beat_q      <= beat_nxt;
            mem_addr_q  <= base_q + ADDR_W'(beat_nxt);
            mem_wdata_q <= lane_q[beat_nxt];
          end
        end
        ARB_V_DRAIN: begin
          // Publish all lanes together so v_rdata only changes when a load completes.
          for (int i = 0; i < LANES - 1; i++) begin
            v_rdata_q[i] <= gather_q[i];
          end
          v_rdata_q[LANES-1] <= mem_rdata;
          v_done_q           <= 1'b1;
          state_q            <= ARB_IDLE;
        end
        ARB_CON: begin
          mem_we_q     <= WE_NONE;
          con_rvalid_q <= con_rd_q;
          state_q      <= ARB_IDLE;
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

  assign mem_addr   = mem_addr_q;
  assign mem_we     = mem_we_q;
  assign mem_wdata  = mem_wdata_q;
  assign v_gnt      = v_gnt_q;
  assign v_done     = v_done_q;
  assign con_gnt    = con_gnt_q;
  assign con_rvalid = con_rvalid_q;
  assign con_rdata  = mem_rdata;
  assign v_rdata0   = v_rdata_q[0];
  assign v_rdata1   = v_rdata_q[1];
  assign v_rdata2   = v_rdata_q[2];
  assign v_rdata3   = v_rdata_q[3];
  assign busy       = (state_q != ARB_IDLE);

endmodule
